// File: rtl/float_copro_pkg.sv
// Shared types and constants for the floating-point coprocessor sequencer and datapath.
package float_copro_pkg;

  localparam int unsigned OPCODE_W    = 11;
  localparam int unsigned CNT_W       = 16;
  localparam int unsigned DEF_ADD_LAT = 2;
  localparam int unsigned DEF_SUB_LAT = 2;
  localparam int unsigned DEF_MUL_LAT = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD = 11'd0,
    OP_SUB = 11'd1,
    OP_MUL = 11'd2
  } opcode_t;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP,
    DRAIN
  } state_t;

endpackage

// File: rtl/float_copro_dp.sv
// Combinational coprocessor datapath: 32-bit wrap-around add, subtract and low-half multiply.
module float_copro_dp
  import float_copro_pkg::*;
(
  input  opcode_t     opcode_i,
  input  logic [31:0] operand_a_i,
  input  logic [31:0] operand_b_i,
  output logic [31:0] result_o
);

  always_comb begin
    result_o = '0;
    case (opcode_i)
      OP_ADD:  result_o = operand_a_i + operand_b_i;
      OP_SUB:  result_o = operand_a_i - operand_b_i;
      OP_MUL:  result_o = operand_a_i * operand_b_i;
      default: result_o = '0;
    endcase
  end

endmodule

// File: rtl/float_copro_ctrl.sv
// Sequencer between the LM32 user-instruction port and float_copro_dp.
// Optional completed-operation counter enabled by FLOAT_COPRO_OPCOUNT_EN.
module float_copro_ctrl
  import float_copro_pkg::*;
#(
  parameter int unsigned ADD_LAT = DEF_ADD_LAT,
  parameter int unsigned SUB_LAT = DEF_SUB_LAT,
  parameter int unsigned MUL_LAT = DEF_MUL_LAT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                user_valid,
  input  logic [OPCODE_W-1:0] user_opcode,
  input  logic [31:0]         user_operand_0,
  input  logic [31:0]         user_operand_1,
  output logic [31:0]         user_result,
  output logic                user_complete,
  output logic                user_error,
  output logic                busy,
  output logic [31:0]         op_count
);

  state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  opcode_t     opcode_q, opcode_d;
  logic [31:0] op0_q, op0_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] result_q, result_d;
  logic        err_q, err_d;
  logic [31:0] dp_result;

  float_copro_dp u_dp (
    .opcode_i    (opcode_q),
    .operand_a_i (op0_q),
    .operand_b_i (op1_q),
    .result_o    (dp_result)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    opcode_d = opcode_q;
    op0_d    = op0_q;
    op1_d    = op1_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      IDLE: begin
        if (user_valid) begin
          opcode_d = opcode_t'(user_opcode);
          op0_d    = user_operand_0;
          op1_d    = user_operand_1;
          err_d    = 1'b0;
          state_d  = EXEC;
          case (opcode_t'(user_opcode))
            OP_ADD: cnt_d = CNT_W'(ADD_LAT - 1);
            OP_SUB: cnt_d = CNT_W'(SUB_LAT - 1);
            OP_MUL: cnt_d = CNT_W'(MUL_LAT - 1);
            default: begin
              // Illegal opcodes bypass the datapath and answer on the next cycle.
              result_d = '0;
              err_d    = 1'b1;
              state_d  = RESP;
            end
          endcase
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          result_d = dp_result;
          state_d  = RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP:    state_d = user_valid ? DRAIN : IDLE;
      DRAIN:   if (!user_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      opcode_q <= OP_ADD;
      op0_q    <= '0;
      op1_q    <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      opcode_q <= opcode_d;
      op0_q    <= op0_d;
      op1_q    <= op1_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign user_result   = result_q;
  assign user_complete = (state_q == RESP);
  assign user_error    = (state_q == RESP) && err_q;
  assign busy          = (state_q == EXEC) || (state_q == RESP);

`ifdef FLOAT_COPRO_OPCOUNT_EN
  logic [31:0] op_count_q, op_count_d;

  always_comb begin
    op_count_d = op_count_q;
    if ((state_q == RESP) && !err_q) op_count_d = op_count_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) op_count_q <= '0;
    else       op_count_q <= op_count_d;
  end

  assign op_count = op_count_q;
`else
  assign op_count = '0;
`endif

endmodule

// File: tb/tb_float_copro_ctrl.sv
// Self-checking bench for float_copro_ctrl: directed cases then randomized operations
// checked against an arithmetic reference model.
module tb_float_copro_ctrl;

  localparam int ADD_LAT = 2;
  localparam int SUB_LAT = 2;
  localparam int MUL_LAT = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        user_valid;
  logic [10:0] user_opcode;
  logic [31:0] user_operand_0;
  logic [31:0] user_operand_1;
  logic [31:0] user_result;
  logic        user_complete;
  logic        user_error;
  logic        busy;
  logic [31:0] op_count;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_count = 32'd0;

  always #5 clk = ~clk;

  float_copro_ctrl #(
    .ADD_LAT (ADD_LAT),
    .SUB_LAT (SUB_LAT),
    .MUL_LAT (MUL_LAT)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .user_valid     (user_valid),
    .user_opcode    (user_opcode),
    .user_operand_0 (user_operand_0),
    .user_operand_1 (user_operand_1),
    .user_result    (user_result),
    .user_complete  (user_complete),
    .user_error     (user_error),
    .busy           (busy),
    .op_count       (op_count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [10:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] prod;
    prod = {32'd0, a} * {32'd0, b};
    case (op)
      11'd0:   return a + b;
      11'd1:   return a - b;
      11'd2:   return prod[31:0];
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [10:0] op);
    case (op)
      11'd0:   return ADD_LAT + 1;
      11'd1:   return SUB_LAT + 1;
      11'd2:   return MUL_LAT + 1;
      default: return 1;
    endcase
  endfunction

  function automatic bit count_enabled();
`ifdef FLOAT_COPRO_OPCOUNT_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  // Issue one request from IDLE; hold = cycles valid stays high after complete.
  task automatic run_op(input logic [10:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input bit drop_early);
    logic [31:0] exp_res;
    bit          legal;
    int          exp_lat;
    int          edges;
    bit          seen;
    legal   = (op < 11'd3);
    exp_res = ref_result(op, a, b);
    exp_lat = ref_latency(op);
    user_valid     = 1'b1;
    user_opcode    = op;
    user_operand_0 = a;
    user_operand_1 = b;
    edges = 0;
    seen  = 1'b0;
    while (!seen && edges < 40) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        user_opcode    = 11'($urandom);
        user_operand_0 = $urandom;
        user_operand_1 = $urandom;
        if (drop_early) user_valid = 1'b0;
      end
      if (user_complete) seen = 1'b1;
      else check("busy_exec", 32'(busy), 32'd1);
    end
    check("complete", 32'(user_complete), 32'd1);
    check("latency", 32'(edges), 32'(exp_lat));
    check("result", user_result, exp_res);
    check("error", 32'(user_error), 32'(!legal));
    check("busy_resp", 32'(busy), 32'd1);
    if (legal && count_enabled()) exp_count = exp_count + 32'd1;
    if (hold > 0 && !drop_early) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("drain_no_complete", 32'(user_complete), 32'd0);
        check("drain_busy", 32'(busy), 32'd0);
        check("drain_result", user_result, exp_res);
      end
    end
    user_valid = 1'b0;
    @(posedge clk); #1;
    check("post_complete", 32'(user_complete), 32'd0);
    check("post_busy", 32'(busy), 32'd0);
    check("post_result", user_result, exp_res);
    check("op_count", op_count, exp_count);
  endtask

  initial begin
    rst_i          = 1'b1;
    user_valid     = 1'b0;
    user_opcode    = '0;
    user_operand_0 = '0;
    user_operand_1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_result", user_result, 32'd0);
    check("rst_complete", 32'(user_complete), 32'd0);
    check("rst_error", 32'(user_error), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_op_count", op_count, 32'd0);
    rst_i = 1'b0;
    @(posedge clk); #1;

    run_op(11'd0, 32'd3, 32'd4, 0, 1'b0);
    run_op(11'd1, 32'd5, 32'd7, 0, 1'b0);
    run_op(11'd2, 32'h0001_0000, 32'h0001_0000, 0, 1'b0);
    run_op(11'd5, 32'd9, 32'd9, 0, 1'b0);
    run_op(11'd0, 32'hFFFF_FFFF, 32'd2, 10, 1'b0);
    run_op(11'd2, 32'd1234, 32'd5678, 0, 1'b1);
    run_op(11'h7FF, 32'd1, 32'd1, 2, 1'b0);

    // Reset in the second EXEC cycle of a multiply discards it.
    user_valid = 1'b1; user_opcode = 11'd2;
    user_operand_0 = 32'd6; user_operand_1 = 32'd7;
    @(posedge clk); #1;
    check("mul_busy1", 32'(busy), 32'd1);
    @(posedge clk); #1;
    check("mul_busy2", 32'(busy), 32'd1);
    rst_i = 1'b1; user_valid = 1'b0;
    @(posedge clk); #1;
    exp_count = 32'd0;
    check("midrst_result", user_result, 32'd0);
    check("midrst_complete", 32'(user_complete), 32'd0);
    check("midrst_error", 32'(user_error), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_op_count", op_count, 32'd0);
    rst_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midrst_no_complete", 32'(user_complete), 32'd0);
    end
    run_op(11'd0, 32'd1, 32'd1, 0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      logic [10:0] op;
      int sel;
      sel = int'($urandom_range(0, 4));
      op  = (sel < 3) ? 11'(sel) : 11'($urandom_range(3, 2047));
      run_op(op, $urandom, $urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/float_copro_ctrl.md
# float_copro_ctrl

Sequencing controller for the floating-point coprocessor datapath. Receives an instruction from the LM32 user-instruction port (opcode plus two operands), registers the operands, and drives the combinational datapath. It holds the datapath inputs stable for a per-opcode latency, then captures the result and returns it with a one-cycle completion pulse. The block sits between the CPU custom-instruction interface and `float_copro_dp`.

## Interface
Parameters:
- ADD_LAT, 2, EXEC cycles for opcode 0 (add); minimum 1
- SUB_LAT, 2, EXEC cycles for opcode 1 (subtract); minimum 1
- MUL_LAT, 4, EXEC cycles for opcode 2 (multiply); minimum 1

Ports:
- clk_i  in  1  single clock; all state changes on its rising edge
- rst_i  in  1  reset, synchronous and active-high
- user_valid  in  1  instruction request; held high by the CPU until it sees user_complete
- user_opcode  in  11  operation select: 0 add, 1 sub, 2 mul, anything else illegal
- user_operand_0  in  32  first operand
- user_operand_1  in  32  second operand
- user_result  out  32  registered result; reset value 0; stable from complete until the next capture
- user_complete  out  1  one-cycle completion pulse; reset value 0
- user_error  out  1  high with user_complete when the opcode was illegal; reset value 0
- busy  out  1  high in EXEC and RESP; reset value 0
- op_count  out  32  count of completed legal operations; reset value 0

## Operation
States:
- IDLE
  - user_valid=1: capture opcode and both operands into registers.
  - Legal opcode: go to EXEC with cnt = LAT(opcode) - 1.
  - Illegal opcode: load user_result=0 and go to RESP with the error flag set.
- EXEC
  - The datapath sees only the captured registers, never the live inputs.
  - cnt decrements each cycle.
  - When cnt==0: load user_result from the datapath and go to RESP.
- RESP
  - user_complete=1 for exactly this cycle; user_error=1 too if the opcode was illegal.
  - Next state is DRAIN if user_valid=1, otherwise IDLE.
- DRAIN
  - Wait for user_valid=0, then go to IDLE.
  - This prevents a held request from being re-issued.

Arithmetic: 32-bit results, wrap-around, no flags. Multiply returns the low 32 bits of the product; subtract is two's-complement.

Boundary conditions:
- user_valid drops during EXEC: the operation still completes and the complete pulse is still emitted. The next state is then IDLE, not DRAIN.
- Operand or opcode changes after capture have no effect.
- rst_i in any state: state goes to IDLE next edge, all outputs return to reset values, cnt=0, the in-flight operation is discarded, and op_count is cleared.
- A new capture is possible at the earliest on the edge after DRAIN or RESP returns to IDLE.

## Timing
- Capture edge N (IDLE, user_valid=1, legal opcode): user_complete is high in the cycle following edge N+LAT. Observed latency from request sample to complete is LAT+1 cycles.
- Illegal opcode: user_complete and user_error are high in the cycle after edge N (latency 1).
- user_result is updated on the same edge that raises user_complete.
- busy rises the cycle after capture and falls after RESP.
- Back-to-back throughput with an immediate valid drop is LAT+2 cycles per operation.

## Configuration
- Macro FLOAT_COPRO_OPCOUNT_EN defined:
  - op_count increments by 1 on each RESP cycle with a legal opcode, wrapping at 2^32.
  - Illegal opcodes are not counted.
- Macro undefined: op_count is tied to 0 and no counter register is synthesized.

## Structure
Shared package float_copro_pkg holds:
- the opcode enum: OP_ADD=0, OP_SUB=1, OP_MUL=2
- the state enum: IDLE, EXEC, RESP, DRAIN
- the 11-bit opcode width constant
- the default latency constants

Sub-module: one instance of float_copro_dp, fed from the captured operand registers. All sequencing lives in float_copro_ctrl.

## Test plan
- Add, default parameters: opcode 0, 3 + 4, valid dropped right after complete → user_result=7, complete 3 cycles after sample, error=0, then IDLE.
- Subtract: opcode 1, 5 - 7 → 0xFFFFFFFE; multiply: opcode 2, 0x00010000 * 0x00010000 → 0x00000000, complete after 5 cycles.
- Illegal opcode 5 → result 0, complete and error high in the next cycle, op_count unchanged.
- Valid held high 10 cycles after complete → exactly one complete pulse, FSM stays in DRAIN until valid=0, no re-issue.
- rst_i asserted in the second EXEC cycle of a multiply → no complete pulse, all outputs 0 next cycle, and a subsequent add 1+1 returns 2 normally.
- With FLOAT_COPRO_OPCOUNT_EN: three legal operations plus one illegal → op_count=3. Without the macro → op_count stays 0.
